// File: rtl/reg_writeback_ctrl.sv
// Register file write-port owner: merges ALU results with buffered
// long-latency results and tracks outstanding destinations for decode stalls.
module reg_writeback_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_dst,
  input  logic        lu_done_valid,
  input  logic [4:0]  lu_done_dst,
  input  logic [31:0] lu_done_data,
  output logic        lu_done_ready,
  input  logic [4:0]  dec_src1,
  input  logic [4:0]  dec_src2,
  input  logic [4:0]  dec_dst,
  output logic        hazard_stall,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        pending_any
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;

  logic [31:0] pend;
  logic [31:0] pend_next;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  logic alu_win;
  logic fifo_empty;
  logic acc_nz;
  logic pop;
  logic bypass;
  logic push;

  // pend[0] is never set, so index 0 contributes nothing to the stall
  assign hazard_stall = pend[dec_src1] | pend[dec_src2] | pend[dec_dst];

  always_comb begin
    head          = mem[rptr];
    alu_win       = alu_valid && (alu_dst != 5'd0);
    fifo_empty    = (count == '0);
    lu_done_ready = (count < CW'(DEPTH));
    acc_nz        = lu_done_valid && lu_done_ready
                    && (lu_done_dst != 5'd0);
    pop           = !alu_win && !fifo_empty;
    bypass        = !alu_win && fifo_empty && acc_nz;
    push          = acc_nz && !bypass;
    clr_mask      = '0;
    set_mask      = '0;
    if (pop)
      clr_mask[head.dst] = 1'b1;
    else if (bypass)
      clr_mask[lu_done_dst] = 1'b1;
    if (lu_issue)
      set_mask[lu_issue_dst] = 1'b1;
    // set applied after clear so a same-cycle reissue stays pending
    pend_next    = (pend & ~clr_mask) | set_mask;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= '{dst: lu_done_dst, data: lu_done_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      pend        <= '0;
      pending_any <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count       <= count + CW'(push) - CW'(pop);
      pend        <= pend_next;
      pending_any <= |pend_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      unique case (1'b1)
        alu_win: begin
          wr_en   <= 1'b1;
          wr_addr <= alu_dst;
          wr_data <= alu_data;
        end
        pop: begin
          wr_en   <= 1'b1;
          wr_addr <= head.dst;
          wr_data <= head.data;
        end
        bypass: begin
          wr_en   <= 1'b1;
          wr_addr <= lu_done_dst;
          wr_data <= lu_done_data;
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl with hand-computed expectations.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_dst;
  logic        lu_done_valid;
  logic [4:0]  lu_done_dst;
  logic [31:0] lu_done_data;
  logic        lu_done_ready;
  logic [4:0]  dec_src1;
  logic [4:0]  dec_src2;
  logic [4:0]  dec_dst;
  logic        hazard_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pending_any;

  int n_checks = 0;
  int n_errors = 0;

  reg_writeback_ctrl #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .lu_issue(lu_issue), .lu_issue_dst(lu_issue_dst),
    .lu_done_valid(lu_done_valid), .lu_done_dst(lu_done_dst),
    .lu_done_data(lu_done_data), .lu_done_ready(lu_done_ready),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_dst(dec_dst),
    .hazard_stall(hazard_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid     = 1'b0;
    alu_dst       = '0;
    alu_data      = '0;
    lu_issue      = 1'b0;
    lu_issue_dst  = '0;
    lu_done_valid = 1'b0;
    lu_done_dst   = '0;
    lu_done_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] d, input logic [31:0] v);
    alu_valid = 1'b1;
    alu_dst   = d;
    alu_data  = v;
  endtask

  task automatic done(input logic [4:0] d, input logic [31:0] v);
    lu_done_valid = 1'b1;
    lu_done_dst   = d;
    lu_done_data  = v;
  endtask

  task automatic issue(input logic [4:0] d);
    lu_issue     = 1'b1;
    lu_issue_dst = d;
  endtask

  task automatic wr(input string tag, input logic [4:0] a,
                    input logic [31:0] v);
    check({tag, "_en"}, 32'(wr_en), 32'd1);
    check({tag, "_addr"}, 32'(wr_addr), 32'(a));
    check({tag, "_data"}, wr_data, v);
  endtask

  initial begin
    idle();
    dec_src1 = '0;
    dec_src2 = '0;
    dec_dst  = '0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_pending", 32'(pending_any), 32'd0);
    check("rst_ready", 32'(lu_done_ready), 32'd1);
    #2 reset = 1'b0;
    tick();

    // plain ALU write
    alu(5'd5, 32'h1234);
    tick();
    idle();
    wr("alu5", 5'd5, 32'h1234);
    check("alu5_pend", 32'(pending_any), 32'd0);

    // issue $7, stall, then result with ALU idle
    issue(5'd7);
    tick();
    idle();
    dec_src1 = 5'd7;
    #1;
    check("haz7_set", 32'(hazard_stall), 32'd1);
    check("pend7_set", 32'(pending_any), 32'd1);
    done(5'd7, 32'hCAFE);
    tick();
    idle();
    wr("lu7", 5'd7, 32'hCAFE);
    check("haz7_clr", 32'(hazard_stall), 32'd0);
    check("pend7_clr", 32'(pending_any), 32'd0);
    dec_src1 = '0;

    // ALU occupies the port while $8,$9 queue up
    issue(5'd8);
    tick();
    issue(5'd9);
    tick();
    idle();
    alu(5'd3, 32'h3);
    done(5'd8, 32'h88);
    tick();
    idle();
    wr("q3", 5'd3, 32'h3);
    check("q_rdy1", 32'(lu_done_ready), 32'd1);
    alu(5'd4, 32'h4);
    done(5'd9, 32'h99);
    tick();
    idle();
    wr("q4", 5'd4, 32'h4);
    check("q_rdy_full", 32'(lu_done_ready), 32'd0);
    alu(5'd6, 32'h6);
    tick();
    idle();
    wr("q6", 5'd6, 32'h6);
    check("q_rdy_full2", 32'(lu_done_ready), 32'd0);
    tick();
    wr("q8", 5'd8, 32'h88);
    check("q_rdy_pop", 32'(lu_done_ready), 32'd1);
    check("q_pend9", 32'(pending_any), 32'd1);
    tick();
    wr("q9", 5'd9, 32'h99);
    check("q_pend_none", 32'(pending_any), 32'd0);
    tick();
    check("q_idle_en", 32'(wr_en), 32'd0);
    check("q_hold_addr", 32'(wr_addr), 32'd9);
    check("q_hold_data", wr_data, 32'h99);

    // ALU to $0 is dropped; issue to $0 marks nothing
    alu(5'd0, 32'hFFFF);
    issue(5'd0);
    tick();
    idle();
    check("z_en", 32'(wr_en), 32'd0);
    check("z_pend", 32'(pending_any), 32'd0);
    issue(5'd10);
    tick();
    idle();
    alu(5'd0, 32'hFFFF);
    done(5'd10, 32'hA0);
    tick();
    idle();
    wr("byp10", 5'd10, 32'hA0);
    check("byp10_pend", 32'(pending_any), 32'd0);

    // same-cycle clear and reissue of $12
    issue(5'd12);
    tick();
    idle();
    done(5'd12, 32'hC);
    issue(5'd12);
    tick();
    idle();
    wr("re12", 5'd12, 32'hC);
    check("re12_pend", 32'(pending_any), 32'd1);
    dec_src2 = 5'd12;
    #1;
    check("re12_haz", 32'(hazard_stall), 32'd1);
    done(5'd12, 32'hD);
    tick();
    idle();
    wr("re12b", 5'd12, 32'hD);
    check("re12b_haz", 32'(hazard_stall), 32'd0);
    dec_src2 = '0;

    // fill the FIFO and scoreboard, then reset mid-cycle
    issue(5'd13);
    tick();
    issue(5'd14);
    tick();
    issue(5'd15);
    tick();
    idle();
    alu(5'd1, 32'h11);
    done(5'd13, 32'hD13);
    tick();
    idle();
    alu(5'd2, 32'h22);
    done(5'd14, 32'hD14);
    tick();
    idle();
    wr("pre_rst", 5'd2, 32'h22);
    check("pre_rst_rdy", 32'(lu_done_ready), 32'd0);
    dec_dst = 5'd15;
    #1;
    check("pre_rst_haz", 32'(hazard_stall), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_en", 32'(wr_en), 32'd0);
    check("arst_addr", 32'(wr_addr), 32'd0);
    check("arst_data", wr_data, 32'd0);
    check("arst_pend", 32'(pending_any), 32'd0);
    check("arst_rdy", 32'(lu_done_ready), 32'd1);
    check("arst_haz", 32'(hazard_stall), 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_en", 32'(wr_en), 32'd0);
    end
    check("post_rst_pend", 32'(pending_any), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
# reg_writeback_ctrl

Writeback controller that owns the single write port of the CPU register file. It merges single-cycle ALU results with results from a long-latency unit (load/multiply/divide), buffering long-latency results in a small FIFO when the ALU holds the port. A 31-entry scoreboard tracks destinations with outstanding long-latency results and drives a decode-stage hazard stall. It is the producer of the register file's `wr_en`/`wr_addr`/`wr_data` inputs; the register file forwards same-cycle writes to its read ports.

## Interface
- `DEPTH`, default 2: long-latency result FIFO depth, power of two, ≥2.
- Clocking: clock `clk`; reset `reset`, asynchronous, active-high.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no backpressure.
- `alu_dst`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `lu_issue`  in  1  long-latency op issued this cycle.
- `lu_issue_dst`  in  5  its destination.
- `lu_done_valid`  in  1  long-latency result offered.
- `lu_done_dst`  in  5  result destination.
- `lu_done_data`  in  32  result data.
- `lu_done_ready`  out  1  result accepted when valid && ready.
- `dec_src1`, `dec_src2`, `dec_dst`  in  5 each  registers used by the instruction in decode.
- `hazard_stall`  out  1  combinational; decode must hold.
- `wr_en`  out  1  registered write enable to the register file.
- `wr_addr`  out  5  registered write address.
- `wr_data`  out  32  registered write data.
- `pending_any`  out  1  registered; any scoreboard bit set.

## Operation
- Scoreboard `pend[31:1]`; `pend[0]` is constant 0.
- Set `pend[d]` on `lu_issue` with `lu_issue_dst=d≠0`. Issue to $0 sets nothing.
- Clear `pend[d]` on the edge that loads a long-latency result for `d` into `wr_*`. Simultaneous set and clear of the same `d`: set wins.
- `hazard_stall` = `pend[dec_src1] | pend[dec_src2] | pend[dec_dst]`, with each term ignored when its index is 0.
- Upstream guarantees:
  - no ALU result targets a pending register;
  - no `lu_issue` targets a pending register.
- FIFO:
  - `lu_done_ready` = (count < `DEPTH`), taken from the registered count. A pop in the same cycle does not raise ready.
  - An accepted result with dst 0 is discarded and never pushed.
- Port arbitration each cycle, in fixed priority:
  1. `alu_valid && alu_dst≠0` → load ALU result into `wr_*`.
  2. Else if FIFO not empty → pop the head into `wr_*`, and clear its pend bit.
  3. Else if an accepted `lu_done` has dst≠0 → bypass it directly into `wr_*` (no FIFO entry), and clear its pend bit.
  4. Else `wr_en` = 0.
- If the ALU wins while a `lu_done` is accepted, that result is pushed to the FIFO. Push and pop in the same cycle are allowed.
- ALU result with dst 0: dropped, and the port is free for the FIFO/bypass in that cycle.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.
- Results leave the FIFO in arrival order.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `pending_any`=0, FIFO empty, all pend bits 0.
- Reset mid-operation discards all buffered results and pending bits immediately; `lu_done_ready`=1 after reset.
- Latency: a result accepted in cycle N appears on `wr_en` in cycle N+1 when it wins the port. Each cycle it loses to the ALU adds one cycle.
- `hazard_stall` deasserts in the cycle `wr_en` carries the pending result. Decode reads in that cycle receive the forwarded value from the register file.
- Throughput: one register write per cycle. Sustained `alu_valid` starves the FIFO, and upstream must eventually idle the ALU.
- `pending_any` reflects the scoreboard after each edge.

## Test plan
- Reset, then ALU writes $5=0x1234 at cycle 1 → `wr_en`=1, `wr_addr`=5, `wr_data`=0x1234 at cycle 2; `pending_any` stays 0.
- `lu_issue` dst 7; decode src1=7 → `hazard_stall`=1. Then `lu_done` $7=0xCAFE with ALU idle → `wr_*`=($7, 0xCAFE) next cycle, `hazard_stall`=0 in that cycle, `pending_any`=0.
- ALU writes $3, $4, $6 in consecutive cycles while `lu_done` $8, $9 arrive in the first two → writes land in order $3, $4, $6, $8, $9. `lu_done_ready`=0 after the 2nd push (DEPTH=2) until the first pop.
- `alu_dst`=0 with data 0xFFFF and `lu_issue_dst`=0 → `wr_en` stays 0, no pend bit set. A concurrently accepted `lu_done` $10 is bypassed instead.
- Clear of $12 and a new `lu_issue` to $12 in the same cycle → `pend[12]` remains 1, and `hazard_stall` stays 1 for src 12.
- Assert `reset` with 2 FIFO entries and 3 pend bits set → outputs go to reset values asynchronously, and no buffered write appears after deassertion.
